// File: rtl/urv_dm_wb_bridge.sv
// urv_dm_wb_bridge: converts the CPU's one-cycle dm_load/dm_store strobes into
// a single Wishbone B4 pipelined cycle, returns one-cycle completion pulses,
// and aborts transfers that a dead slave never answers (timeout or err).
module urv_dm_wb_bridge #(
  parameter int unsigned g_timeout_cycles = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_data_s_i,
  input  logic [3:0]  dm_data_select_i,
  input  logic        dm_store_i,
  input  logic        dm_load_i,
  output logic [31:0] dm_data_l_o,
  output logic        dm_load_done_o,
  output logic        dm_store_done_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_stall_i,
  output logic        bus_err_o,
  output logic [31:0] bus_err_addr_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_STROBE   = 2'd1,
    ST_WAIT_ACK = 2'd2
  } t_state;

  // The counter holds 0 in the first cyc cycle, so the abort decision is taken
  // when it shows g_timeout_cycles-1; the registered done/err pulse then lands
  // exactly g_timeout_cycles cycles after cyc rose.
  localparam bit          LP_TMO_EN   = (g_timeout_cycles != 0);
  localparam logic [15:0] LP_TMO_LAST = LP_TMO_EN ? 16'(g_timeout_cycles - 1) : 16'd0;

  t_state      r_state;
  t_state      w_state_nxt;
  logic        w_start;
  logic        w_active;
  logic        w_done_ok;
  logic        w_done_fail;
  logic        w_cyc;
  logic        w_stb;
  logic        w_tmo;

  logic [15:0] r_tmo_cnt;
  logic [31:0] r_adr;
  logic [31:0] r_dat;
  logic [3:0]  r_sel;
  logic        r_we;
  logic [31:0] r_byte_adr;
  logic [31:0] r_data_l;
  logic        r_load_done;
  logic        r_store_done;
  logic        r_bus_err;
  logic [31:0] r_err_adr;

  assign w_tmo = LP_TMO_EN && (r_tmo_cnt == LP_TMO_LAST);

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic, bus strobes and completion decode (ack beats err/timeout)
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_active    = 1'b0;
    w_done_ok   = 1'b0;
    w_done_fail = 1'b0;
    w_cyc       = 1'b0;
    w_stb       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (dm_store_i || dm_load_i) begin
          w_start     = 1'b1;
          w_state_nxt = ST_STROBE;
        end
      end
      ST_STROBE: begin
        w_cyc    = 1'b1;
        w_stb    = 1'b1;
        w_active = 1'b1;
        if (wb_ack_i)                 w_done_ok   = 1'b1;
        else if (wb_err_i || w_tmo)   w_done_fail = 1'b1;
        if (wb_ack_i || wb_err_i || w_tmo) w_state_nxt = ST_IDLE;
        else if (!wb_stall_i)              w_state_nxt = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        w_cyc    = 1'b1;
        w_active = 1'b1;
        if (wb_ack_i)                 w_done_ok   = 1'b1;
        else if (wb_err_i || w_tmo)   w_done_fail = 1'b1;
        if (wb_ack_i || wb_err_i || w_tmo) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Capture the request; values stay put while idle, only cyc/stb qualify them
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_adr      <= 32'h0;
      r_dat      <= 32'h0;
      r_sel      <= 4'h0;
      r_we       <= 1'b0;
      r_byte_adr <= 32'h0;
    end else if (w_start) begin
      r_adr      <= {dm_addr_i[31:2], 2'b00};
      r_dat      <= dm_data_s_i;
      r_sel      <= dm_data_select_i;
      r_we       <= dm_store_i;
      r_byte_adr <= dm_addr_i;
    end
  end

  // Timeout counter: cleared on entry to STROBE, counts while cyc is high
  always_ff @(posedge clk_i) begin
    if (rst_i)         r_tmo_cnt <= 16'd0;
    else if (w_start)  r_tmo_cnt <= 16'd0;
    else if (w_active) r_tmo_cnt <= r_tmo_cnt + 16'd1;
  end

  // Completion pulses, load data return and error reporting
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_load_done  <= 1'b0;
      r_store_done <= 1'b0;
      r_bus_err    <= 1'b0;
      r_data_l     <= 32'h0;
      r_err_adr    <= 32'h0;
    end else begin
      r_load_done  <= 1'b0;
      r_store_done <= 1'b0;
      r_bus_err    <= 1'b0;
      if (w_done_ok || w_done_fail) begin
        r_store_done <= r_we;
        r_load_done  <= ~r_we;
        if (!r_we) r_data_l <= w_done_ok ? wb_dat_i : 32'h0;
      end
      if (w_done_fail) begin
        r_bus_err <= 1'b1;
        r_err_adr <= r_byte_adr;
      end
    end
  end

  assign wb_adr_o        = r_adr;
  assign wb_dat_o        = r_dat;
  assign wb_sel_o        = r_sel;
  assign wb_we_o         = r_we;
  assign wb_cyc_o        = w_cyc;
  assign wb_stb_o        = w_stb;
  assign dm_data_l_o     = r_data_l;
  assign dm_load_done_o  = r_load_done;
  assign dm_store_done_o = r_store_done;
  assign bus_err_o       = r_bus_err;
  assign bus_err_addr_o  = r_err_adr;
  assign busy_o          = (r_state != ST_IDLE);

endmodule

// File: tb/tb_urv_dm_wb_bridge.sv
// Directed bench for urv_dm_wb_bridge (timeout set to 8 cycles).
// Cycle 0 of every transaction is the cycle the CPU strobe is high.
module tb_urv_dm_wb_bridge;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] dm_addr_i = '0;
  logic [31:0] dm_data_s_i = '0;
  logic [3:0]  dm_data_select_i = '0;
  logic        dm_store_i = 1'b0;
  logic        dm_load_i = 1'b0;
  logic [31:0] dm_data_l_o;
  logic        dm_load_done_o;
  logic        dm_store_done_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack_i = 1'b0;
  logic        wb_err_i = 1'b0;
  logic        wb_stall_i = 1'b0;
  logic        bus_err_o;
  logic [31:0] bus_err_addr_o;
  logic        busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  urv_dm_wb_bridge #(.g_timeout_cycles(8)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .dm_addr_i(dm_addr_i), .dm_data_s_i(dm_data_s_i),
    .dm_data_select_i(dm_data_select_i),
    .dm_store_i(dm_store_i), .dm_load_i(dm_load_i),
    .dm_data_l_o(dm_data_l_o), .dm_load_done_o(dm_load_done_o),
    .dm_store_done_o(dm_store_done_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .wb_stall_i(wb_stall_i),
    .bus_err_o(bus_err_o), .bus_err_addr_o(bus_err_addr_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  localparam int R_ACK = 0, R_ERR = 1, R_BOTH = 2, R_NONE = 3;

  typedef struct {
    logic        st;
    logic        ld;
    logic [31:0] addr;
    logic [31:0] wdat;
    logic [3:0]  sel;
    int          stall_n;   // stall high in cycles 1..stall_n
    int          resp_cyc;  // cycle in which the slave responds
    int          resp;
    logic [31:0] rdat;
    logic [31:0] e_adr;
    logic        e_we;
    int          e_stb;     // cycles with stb high
    int          e_done;    // cycle in which the done pulse is seen
    logic [31:0] e_dl;
    int          e_err;     // number of bus_err pulses
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic do_txn(input vec_t v, input string tag);
    int stb_cnt = 0, cyc_cnt = 0, done_cnt = 0, wrong_cnt = 0, err_cnt = 0;
    int done_cyc = -1, err_cyc = -1;
    logic [31:0] dl_at = '0, dl_end = '0, adr_at = '0, dat_at = '0, eadr_at = '0;
    logic [3:0]  sel_at = '0;
    logic        we_at = 1'b0, busy_end = 1'b1;
    for (int c = 0; c < 14; c++) begin
      dm_store_i       = (c == 0) && v.st;
      dm_load_i        = (c == 0) && v.ld;
      dm_addr_i        = v.addr;
      dm_data_s_i      = v.wdat;
      dm_data_select_i = v.sel;
      wb_stall_i       = (c >= 1) && (c <= v.stall_n);
      wb_ack_i         = (c == v.resp_cyc) && (v.resp == R_ACK || v.resp == R_BOTH);
      wb_err_i         = (c == v.resp_cyc) && (v.resp == R_ERR || v.resp == R_BOTH);
      wb_dat_i         = (c == v.resp_cyc) ? v.rdat : 32'h0;
      @(negedge clk);
      if (c == 1) begin
        adr_at = wb_adr_o; dat_at = wb_dat_o; sel_at = wb_sel_o; we_at = wb_we_o;
      end
      if (wb_stb_o) stb_cnt++;
      if (wb_cyc_o) cyc_cnt++;
      if ((v.st ? dm_store_done_o : dm_load_done_o) === 1'b1) begin
        done_cnt++; done_cyc = c; dl_at = dm_data_l_o;
      end
      if ((v.st ? dm_load_done_o : dm_store_done_o) === 1'b1) wrong_cnt++;
      if (bus_err_o === 1'b1) begin
        err_cnt++; err_cyc = c; eadr_at = bus_err_addr_o;
      end
      if (c == 13) begin
        dl_end = dm_data_l_o; busy_end = busy_o;
      end
      @(posedge clk); #1;
    end
    chk({tag, "_adr"}, adr_at, v.e_adr);
    chk({tag, "_dat"}, dat_at, v.wdat);
    chk({tag, "_sel"}, {28'h0, sel_at}, {28'h0, v.sel});
    chk({tag, "_we"}, {31'h0, we_at}, {31'h0, v.e_we});
    chk({tag, "_stb_cycles"}, stb_cnt, v.e_stb);
    chk({tag, "_cyc_cycles"}, cyc_cnt, v.e_done - 1);
    chk({tag, "_done_count"}, done_cnt, 1);
    chk({tag, "_done_cycle"}, done_cyc, v.e_done);
    chk({tag, "_other_done"}, wrong_cnt, 0);
    chk({tag, "_load_data"}, dl_at, v.e_dl);
    chk({tag, "_data_hold"}, dl_end, v.e_dl);
    chk({tag, "_busy_end"}, {31'h0, busy_end}, 32'h0);
    chk({tag, "_err_count"}, err_cnt, v.e_err);
    if (v.e_err != 0) begin
      chk({tag, "_err_cycle"}, err_cyc, v.e_done);
      chk({tag, "_err_addr"}, eadr_at, v.addr);
    end
  endtask

  function automatic vec_t mk(input logic st, input logic ld, input logic [31:0] addr,
                              input logic [31:0] wdat, input logic [3:0] sel,
                              input int stall_n, input int resp_cyc, input int resp,
                              input logic [31:0] rdat, input logic [31:0] e_adr,
                              input logic e_we, input int e_stb, input int e_done,
                              input logic [31:0] e_dl, input int e_err);
    vec_t v;
    v.st = st; v.ld = ld; v.addr = addr; v.wdat = wdat; v.sel = sel;
    v.stall_n = stall_n; v.resp_cyc = resp_cyc; v.resp = resp; v.rdat = rdat;
    v.e_adr = e_adr; v.e_we = e_we; v.e_stb = e_stb; v.e_done = e_done;
    v.e_dl = e_dl; v.e_err = e_err;
    return v;
  endfunction

  initial begin
    int ld_cnt, st_cnt, cyc_cnt, err_cnt, ld_cyc, st_cyc;
    logic [31:0] dl_at, adr_at;
    logic we_at;

    //         st  ld  addr          wdat          sel    stl rc  resp    rdat          e_adr         we stb done e_dl          err
    vecs[0] = mk(1, 0, 32'h0000_1006, 32'h00AB_0000, 4'b0100, 0, 2, R_ACK,  32'h0,        32'h0000_1004, 1, 1, 3, 32'h0,        0);
    vecs[1] = mk(0, 1, 32'h3000_0008, 32'h0,        4'b1111, 4, 6, R_ACK,  32'hDEAD_BEEF, 32'h3000_0008, 0, 5, 7, 32'hDEAD_BEEF, 0);
    vecs[2] = mk(1, 1, 32'h0000_0044, 32'h0000_5555, 4'b0011, 0, 1, R_ACK,  32'h0,        32'h0000_0044, 1, 1, 2, 32'hDEAD_BEEF, 0);
    vecs[3] = mk(0, 1, 32'h2000_0010, 32'h0,        4'b1111, 0, 2, R_ERR,  32'hFFFF_FFFF, 32'h2000_0010, 0, 1, 3, 32'h0,        1);
    vecs[4] = mk(0, 1, 32'h0000_0103, 32'h0,        4'b1000, 0, 3, R_BOTH, 32'h1234_5678, 32'h0000_0100, 0, 1, 4, 32'h1234_5678, 0);
    vecs[5] = mk(0, 1, 32'h0000_0200, 32'h0,        4'b1111, 0, 0, R_NONE, 32'h0,        32'h0000_0200, 0, 1, 9, 32'h0,        1);
    vecs[6] = mk(0, 1, 32'h0000_0204, 32'h0,        4'b1111, 0, 8, R_ACK,  32'hCAFE_F00D, 32'h0000_0204, 0, 1, 9, 32'hCAFE_F00D, 0);
    vecs[7] = mk(1, 0, 32'h0000_0307, 32'h1122_3344, 4'b1000, 99, 0, R_NONE, 32'h0,       32'h0000_0304, 1, 8, 9, 32'hCAFE_F00D, 1);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cyc", {31'h0, wb_cyc_o}, 32'h0);
    chk("rst_stb", {31'h0, wb_stb_o}, 32'h0);
    chk("rst_busy", {31'h0, busy_o}, 32'h0);
    chk("rst_done", {30'h0, dm_load_done_o, dm_store_done_o}, 32'h0);
    chk("rst_err", {31'h0, bus_err_o}, 32'h0);
    chk("rst_err_addr", bus_err_addr_o, 32'h0);
    chk("rst_data_l", dm_data_l_o, 32'h0);
    chk("rst_adr", wb_adr_o, 32'h0);
    chk("rst_dat", wb_dat_o, 32'h0);
    chk("rst_sel_we", {27'h0, wb_sel_o, wb_we_o}, 32'h0);
    @(posedge clk); #1;
    rst_i = 1'b0;

    for (int i = 0; i < 8; i++) do_txn(vecs[i], $sformatf("v%0d", i));

    // Second strobe during WAIT_ACK is ignored
    ld_cnt = 0; st_cnt = 0; cyc_cnt = 0; ld_cyc = -1; dl_at = '0; adr_at = '0; we_at = 1'b1;
    for (int c = 0; c < 8; c++) begin
      dm_load_i   = (c == 0);
      dm_store_i  = (c == 2);
      dm_addr_i   = (c == 2) ? 32'h0000_0600 : 32'h0000_0500;
      dm_data_s_i = 32'h0000_FFFF;
      wb_stall_i  = 1'b0;
      wb_ack_i    = (c == 3);
      wb_err_i    = 1'b0;
      wb_dat_i    = (c == 3) ? 32'h0BAD_F00D : 32'h0;
      @(negedge clk);
      if (wb_cyc_o) cyc_cnt++;
      if (dm_store_done_o) st_cnt++;
      if (dm_load_done_o) begin ld_cnt++; ld_cyc = c; dl_at = dm_data_l_o; end
      if (c == 4) begin adr_at = wb_adr_o; we_at = wb_we_o; end
      @(posedge clk); #1;
    end
    chk("ign_load_done_count", ld_cnt, 1);
    chk("ign_load_done_cycle", ld_cyc, 4);
    chk("ign_store_done_count", st_cnt, 0);
    chk("ign_cyc_cycles", cyc_cnt, 3);
    chk("ign_load_data", dl_at, 32'h0BAD_F00D);
    chk("ign_adr", adr_at, 32'h0000_0500);
    chk("ign_we", {31'h0, we_at}, 32'h0);

    // Reset while in WAIT_ACK, late ack ignored
    ld_cnt = 0; cyc_cnt = 0; err_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      dm_load_i  = (c == 0);
      dm_store_i = 1'b0;
      dm_addr_i  = 32'h0000_0700;
      rst_i      = (c == 2);
      wb_ack_i   = (c == 3);
      wb_dat_i   = (c == 3) ? 32'h0000_0099 : 32'h0;
      @(negedge clk);
      if (wb_cyc_o) cyc_cnt++;
      if (dm_load_done_o || dm_store_done_o) ld_cnt++;
      if (bus_err_o) err_cnt++;
      if (c == 3) begin
        chk("rst_wait_cyc", {31'h0, wb_cyc_o}, 32'h0);
        chk("rst_wait_stb", {31'h0, wb_stb_o}, 32'h0);
        chk("rst_wait_busy", {31'h0, busy_o}, 32'h0);
      end
      @(posedge clk); #1;
    end
    chk("rst_wait_done_count", ld_cnt, 0);
    chk("rst_wait_err_count", err_cnt, 0);
    chk("rst_wait_cyc_cycles", cyc_cnt, 2);
    do_txn(mk(0, 1, 32'h0000_0710, 32'h0, 4'b1111, 0, 2, R_ACK, 32'h1357_9BDF,
              32'h0000_0710, 0, 1, 3, 32'h1357_9BDF, 0), "after_rst");

    // Back-to-back: load strobed in the store's done cycle
    ld_cyc = -1; st_cyc = -1; dl_at = '0; adr_at = '0; we_at = 1'b1; ld_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      dm_store_i       = (c == 0);
      dm_load_i        = (c == 3);
      dm_addr_i        = (c >= 3) ? 32'h0000_0904 : 32'h0000_0800;
      dm_data_s_i      = 32'hA5A5_A5A5;
      dm_data_select_i = 4'b1111;
      wb_ack_i         = (c == 2) || (c == 5);
      wb_dat_i         = (c == 5) ? 32'h600D_CAFE : 32'h0;
      @(negedge clk);
      if (dm_store_done_o) st_cyc = c;
      if (dm_load_done_o) begin ld_cnt++; ld_cyc = c; dl_at = dm_data_l_o; end
      if (c == 4) begin
        adr_at = wb_adr_o; we_at = wb_we_o;
        chk("b2b_stb_c4", {31'h0, wb_stb_o}, 32'h1);
      end
      @(posedge clk); #1;
    end
    chk("b2b_store_done_cycle", st_cyc, 3);
    chk("b2b_load_done_cycle", ld_cyc, 6);
    chk("b2b_load_done_count", ld_cnt, 1);
    chk("b2b_load_adr", adr_at, 32'h0000_0904);
    chk("b2b_load_we", {31'h0, we_at}, 32'h0);
    chk("b2b_load_data", dl_at, 32'h600D_CAFE);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
